// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: shared widths and the storage record for the instruction
// queue that sits between instruction fetch and decode.
//   INSTRUCTION_WIDTH - width of one fetched instruction word
//   ADDRESS_WIDTH     - width of a program counter
//   ENABLE/DISABLE    - single-bit strobe levels
//   iq_entry_t        - one buffered {instruction, pc} pair
package inst_queue_pkg;

    localparam int unsigned INSTRUCTION_WIDTH = 32;
    localparam int unsigned ADDRESS_WIDTH     = 32;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef struct packed {
        logic [INSTRUCTION_WIDTH-1:0] inst;
        logic [ADDRESS_WIDTH-1:0]     pc;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue.sv
// inst_queue: circular FIFO of {instruction, pc} pairs between fetch and
// decode. Hands out at most one entry per cycle and is flushed wholesale by
// the ROB redirect.
// Ports:
//   clk_in              - clock, rising edge
//   rst_in              - synchronous active-low reset
//   rdy_in              - global run enable; low pauses pop and flush
//   ifetch_inst_en_in   - push strobe from fetch
//   ifetch_inst_in      - instruction to push
//   ifetch_pc_in        - pc of the pushed instruction
//   ifetch_rdy_out      - fetch may issue a request this cycle (combinational)
//   decoder_rdy_in      - decode can accept an instruction this cycle
//   decoder_inst_en_out - registered one-cycle valid pulse
//   decoder_inst_out    - registered instruction
//   decoder_pc_out      - registered pc
//   rob_en_in           - redirect flush strobe
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned PTR_WIDTH = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         ifetch_inst_en_in,
    input  logic [INSTRUCTION_WIDTH-1:0] ifetch_inst_in,
    input  logic [ADDRESS_WIDTH-1:0]     ifetch_pc_in,
    output logic                         ifetch_rdy_out,
    input  logic                         decoder_rdy_in,
    output logic                         decoder_inst_en_out,
    output logic [INSTRUCTION_WIDTH-1:0] decoder_inst_out,
    output logic [ADDRESS_WIDTH-1:0]     decoder_pc_out,
    input  logic                         rob_en_in
);

    localparam logic [PTR_WIDTH:0] LP_DEPTH    = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] LP_HIGH_WM  = (PTR_WIDTH+1)'(DEPTH - 1);

    iq_entry_t              r_mem [DEPTH];
    logic [PTR_WIDTH-1:0]   r_head;
    logic [PTR_WIDTH-1:0]   r_tail;
    logic [PTR_WIDTH:0]     r_count;

    logic w_flush;
    logic w_push;
    logic w_pop;

    // A push arriving with the flush is stale pre-redirect fetch and is dropped.
    // A push into a full queue is a protocol error and is dropped as well.
    assign w_flush = rdy_in && rob_en_in;
    assign w_push  = ifetch_inst_en_in && !w_flush && (r_count != LP_DEPTH);
    // No bypass: an entry must be resident before the edge to be popped.
    assign w_pop   = rdy_in && !rob_en_in && decoder_rdy_in && (r_count != '0);

    // One slot is held back for the push fetch has already registered when
    // it samples ready in the same cycle.
    assign ifetch_rdy_out = (r_count < LP_HIGH_WM) && !rob_en_in;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk_in) begin
        if (rst_in && w_push) begin
            r_mem[r_tail] <= '{inst: ifetch_inst_in, pc: ifetch_pc_in};
        end
    end

    always_ff @(posedge clk_in) begin
        decoder_inst_en_out <= DISABLE;
        decoder_inst_out    <= '0;
        decoder_pc_out      <= '0;
        if (!rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_WIDTH'(1);
            end
            if (w_pop) begin
                decoder_inst_en_out <= ENABLE;
                decoder_inst_out    <= r_mem[r_head].inst;
                decoder_pc_out      <= r_mem[r_head].pc;
                r_head              <= r_head + PTR_WIDTH'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PTR_WIDTH+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (PTR_WIDTH+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: self-checking bench for inst_queue. A queue-based reference
// model tracks the buffered pairs; every step compares ifetch_rdy_out before
// the edge and the decoder_* outputs after it.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic                         clk_in = 1'b0;
    logic                         rst_in = 1'b0;
    logic                         rdy_in = 1'b0;
    logic                         ifetch_inst_en_in = 1'b0;
    logic [INSTRUCTION_WIDTH-1:0] ifetch_inst_in = '0;
    logic [ADDRESS_WIDTH-1:0]     ifetch_pc_in = '0;
    logic                         ifetch_rdy_out;
    logic                         decoder_rdy_in = 1'b0;
    logic                         decoder_inst_en_out;
    logic [INSTRUCTION_WIDTH-1:0] decoder_inst_out;
    logic [ADDRESS_WIDTH-1:0]     decoder_pc_out;
    logic                         rob_en_in = 1'b0;

    inst_queue #(.DEPTH(16), .PTR_WIDTH(4)) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .rdy_in              (rdy_in),
        .ifetch_inst_en_in   (ifetch_inst_en_in),
        .ifetch_inst_in      (ifetch_inst_in),
        .ifetch_pc_in        (ifetch_pc_in),
        .ifetch_rdy_out      (ifetch_rdy_out),
        .decoder_rdy_in      (decoder_rdy_in),
        .decoder_inst_en_out (decoder_inst_en_out),
        .decoder_inst_out    (decoder_inst_out),
        .decoder_pc_out      (decoder_pc_out),
        .rob_en_in           (rob_en_in)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the queue holds {inst, pc} in FIFO order.
    logic [63:0] q[$];
    bit          mv = 0;
    logic        e_en;
    logic [31:0] e_inst;
    logic [31:0] e_pc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    task automatic step(input logic rst, input logic rdy, input logic push,
                        input logic [31:0] pc, input logic drdy, input logic rob,
                        output logic rdy_seen);
        int pre;
        logic [63:0] tmp;
        rst_in = rst; rdy_in = rdy; ifetch_inst_en_in = push;
        ifetch_pc_in = pc; ifetch_inst_in = mk_inst(pc);
        decoder_rdy_in = drdy; rob_en_in = rob;
        #1;
        rdy_seen = ifetch_rdy_out;
        if (mv) chk("ifetch_rdy", 64'(ifetch_rdy_out), 64'((q.size() < DEPTH - 1) && !rob));
        @(posedge clk_in);
        e_en = 1'b0; e_inst = '0; e_pc = '0;
        if (!rst) begin
            q.delete();
            mv = 1;
        end else if (rdy && rob) begin
            q.delete();
        end else begin
            pre = q.size();
            if (rdy && drdy && pre != 0) begin
                tmp = q.pop_front();
                e_en = 1'b1; e_inst = tmp[63:32]; e_pc = tmp[31:0];
            end
            if (push) begin
                chk("no_overflow", 64'(pre == DEPTH), 64'(0));
                if (pre < DEPTH) q.push_back({mk_inst(pc), pc});
            end
        end
        #1;
        if (mv) begin
            chk("dec_en", 64'(decoder_inst_en_out), 64'(e_en));
            chk("dec_inst", 64'(decoder_inst_out), 64'(e_inst));
            chk("dec_pc", 64'(decoder_pc_out), 64'(e_pc));
        end
    endtask

    typedef struct {
        logic        rst, rdy, push, drdy, rob;
        logic [31:0] pc;
        logic        x_en;
        logic [31:0] x_inst, x_pc;
        logic        x_rdy;
    } vec_t;

    initial begin
        vec_t  vt[5];
        logic  r;
        logic  req;
        int    pushes;
        logic [31:0] pcv, last_pc;

        // Reset, then a single push that surfaces two edges later.
        vt[0] = '{0,0,0,0,0, 32'h0, 0, 32'h0, 32'h0, 1};
        vt[1] = '{0,0,0,0,0, 32'h0, 0, 32'h0, 32'h0, 1};
        vt[2] = '{1,1,1,1,0, 32'h0, 0, 32'h0, 32'h0, 1};
        vt[3] = '{1,1,0,1,0, 32'h0, 1, 32'hA5A5_0013, 32'h0, 1};
        vt[4] = '{1,1,0,1,0, 32'h0, 0, 32'h0, 32'h0, 1};
        for (int i = 0; i < 5; i++) begin
            step(vt[i].rst, vt[i].rdy, vt[i].push, vt[i].pc, vt[i].drdy, vt[i].rob, r);
            chk("vec_en", 64'(decoder_inst_en_out), 64'(vt[i].x_en));
            chk("vec_inst", 64'(decoder_inst_out), 64'(vt[i].x_inst));
            chk("vec_pc", 64'(decoder_pc_out), 64'(vt[i].x_pc));
            chk("vec_rdy", 64'(ifetch_rdy_out), 64'(vt[i].x_rdy));
        end

        // Fill: fetch pushes one cycle after it sees ready.
        req = 1'b0; pushes = 0; pcv = 32'h0; last_pc = 32'hFFFF_FFFF;
        for (int k = 0; k < 24; k++) begin
            step(1, 1, req, pcv, 0, 0, r);
            if (req) begin pushes++; last_pc = pcv; pcv += 4; end
            req = r;
        end
        chk("fill_pushes", 64'(pushes), 64'(16));
        chk("fill_last_pc", 64'(last_pc), 64'h3C);
        chk("fill_rdy_low", 64'(ifetch_rdy_out), 64'(0));
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 0, 0, 1, 0, r);
            chk("drain_en", 64'(decoder_inst_en_out), 64'(1));
            chk("drain_pc", 64'(decoder_pc_out), 64'(i * 4));
        end

        // Steady push+pop at occupancy 3; pointers wrap more than once.
        step(0, 1, 0, 0, 0, 0, r);
        pcv = 32'h400;
        for (int i = 0; i < 3; i++) begin step(1, 1, 1, pcv, 0, 0, r); pcv += 4; end
        last_pc = 32'h3FC;
        for (int i = 0; i < 40; i++) begin
            step(1, 1, 1, pcv, 1, 0, r);
            pcv += 4;
            chk("wrap_en", 64'(decoder_inst_en_out), 64'(1));
            chk("wrap_pc", 64'(decoder_pc_out), 64'(last_pc + 4));
            last_pc = decoder_pc_out;
        end
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1, 0, r);

        // Flush with a concurrent push.
        for (int i = 0; i < 5; i++) step(1, 1, 1, 32'h500 + i * 4, 0, 0, r);
        step(1, 1, 1, 32'h100, 1, 1, r);
        chk("flush_en", 64'(decoder_inst_en_out), 64'(0));
        step(1, 1, 1, 32'h200, 1, 0, r);
        chk("flush_empty_en", 64'(decoder_inst_en_out), 64'(0));
        step(1, 1, 0, 0, 1, 0, r);
        chk("post_flush_pc", 64'(decoder_pc_out), 64'h200);
        step(1, 1, 0, 0, 1, 0, r);
        chk("no_stale_en", 64'(decoder_inst_en_out), 64'(0));

        // Stall with rdy_in low while a push lands.
        step(1, 1, 1, 32'h40, 0, 0, r);
        step(1, 1, 1, 32'h44, 0, 0, r);
        step(1, 0, 1, 32'h80, 1, 0, r);
        chk("stall_en0", 64'(decoder_inst_en_out), 64'(0));
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 0, 1, 0, r);
            chk("stall_en", 64'(decoder_inst_en_out), 64'(0));
        end
        step(1, 1, 0, 0, 1, 0, r); chk("resume0", 64'(decoder_pc_out), 64'h40);
        step(1, 1, 0, 0, 1, 0, r); chk("resume1", 64'(decoder_pc_out), 64'h44);
        step(1, 1, 0, 0, 1, 0, r); chk("resume2", 64'(decoder_pc_out), 64'h80);
        step(1, 1, 0, 0, 1, 0, r); chk("resume_end", 64'(decoder_inst_en_out), 64'(0));

        // Reset during a push+pop cycle.
        for (int i = 0; i < 7; i++) step(1, 1, 1, 32'h700 + i * 4, 0, 0, r);
        step(0, 1, 1, 32'h7F0, 1, 0, r);
        chk("rst_mid_en", 64'(decoder_inst_en_out), 64'(0));
        chk("rst_mid_pc", 64'(decoder_pc_out), 64'(0));
        chk("rst_mid_rdy", 64'(ifetch_rdy_out), 64'(1));
        step(1, 1, 0, 0, 1, 0, r);
        chk("rst_mid_empty", 64'(decoder_inst_en_out), 64'(0));

        // Randomized traffic obeying the fetch ready protocol.
        req = 1'b0; pcv = 32'h1000;
        for (int k = 0; k < 600; k++) begin
            logic p;
            p = req && ($urandom_range(0, 3) != 0);
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) != 0), p, pcv,
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0), r);
            if (p) pcv += 4;
            req = r;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
